// File: rtl/ltrk_pkg.sv
// Shared error encoding, first-error codes and default queue entry layout for the load/writeback tracker.
package ltrk_pkg;

   localparam int ERR_OVERFLOW      = 0;
   localparam int ERR_SPURIOUS      = 1;
   localparam int ERR_RD_MISMATCH   = 2;
   localparam int ERR_DATA_MISMATCH = 3;
   localparam int ERR_TIMEOUT       = 4;
   localparam int ERR_BITS          = 5;

   typedef enum logic [2:0] {
      FE_NONE          = 3'd0,
      FE_OVERFLOW      = 3'd1,
      FE_SPURIOUS      = 3'd2,
      FE_RD_MISMATCH   = 3'd3,
      FE_DATA_MISMATCH = 3'd4,
      FE_TIMEOUT       = 3'd5
   } first_err_e;

   localparam int LTRK_RD_WIDTH   = 5;
   localparam int LTRK_DATA_WIDTH = 32;

   typedef struct packed {
      logic [LTRK_RD_WIDTH-1:0]   rd;
      logic [LTRK_DATA_WIDTH-1:0] data;
   } ltrk_entry_t;

   // Lowest set error bit decides the code when several fire together.
   function automatic first_err_e first_err_code(input logic [ERR_BITS-1:0] ev);
      first_err_code = FE_NONE;
      for (int i = ERR_BITS - 1; i >= 0; i--) begin
         if (ev[i]) first_err_code = first_err_e'(3'(i + 1));
      end
   endfunction

endpackage

// File: rtl/ltrk_fifo.sv
// Circular buffer with combinational head lookahead; push and pop may coincide even when full.
// Caller guarantees no pop when empty and no push when full without a pop; flush empties in one cycle.
module ltrk_fifo
   import ltrk_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = ltrk_entry_t,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int CNT_W   = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  entry_t           push_entry,
   output entry_t           head_entry,
   output logic [PTR_W-1:0] head_ptr,
   output logic [PTR_W-1:0] tail_ptr,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   entry_t mem [DEPTH];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else if (flush) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         if (push) tail_ptr <= tail_ptr + PTR_W'(1);
         if (pop)  head_ptr <= head_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Payload storage carries no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clock) begin
      if (push && !flush) mem[tail_ptr] <= push_entry;
   end

   assign head_entry = mem[head_ptr];
   assign full       = (count == CNT_W'(DEPTH));
   assign empty      = (count == '0);

endmodule

// File: rtl/load_writeback_tracker.sv
// In-order load/writeback scoreboard: each captured load must retire once, in order, matching rd/data, within the latency limit.
// Error pulses are registered one cycle after the event; no backpressure, overflowing loads are dropped and flagged.
module load_writeback_tracker
   import ltrk_pkg::*;
#(
   parameter int  DATA_WIDTH        = 32,
   parameter int  RD_WIDTH          = 5,
   parameter int  DEPTH             = 4,
   parameter int  MAX_LATENCY       = 8,
   parameter int  STRICT_NEXT_CYCLE = 0,
   localparam int CNT_W             = $clog2(DEPTH) + 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  mem_valid,
   input  logic                  mem_read,
   input  logic                  mem_reg_write,
   input  logic [RD_WIDTH-1:0]   mem_rd,
   input  logic [DATA_WIDTH-1:0] mem_data,
   input  logic                  wb_valid,
   input  logic                  wb_mem_read,
   input  logic                  wb_reg_write,
   input  logic [RD_WIDTH-1:0]   wb_rd,
   input  logic [DATA_WIDTH-1:0] wb_data,
   input  logic                  flush,
   input  logic                  clear_errors,
   output logic [CNT_W-1:0]      outstanding,
   output logic                  full,
   output logic [ERR_BITS-1:0]   err_sticky,
   output logic [ERR_BITS-1:0]   err_pulse,
   output logic [2:0]            first_err
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int LIMIT   = (STRICT_NEXT_CYCLE != 0) ? 1 : MAX_LATENCY;
   localparam int AGE_MAX = MAX_LATENCY + 1;
   localparam int AGE_W   = $clog2(AGE_MAX + 1);
   localparam logic [AGE_W-1:0] AGE_SAT  = AGE_W'(AGE_MAX);
   localparam logic [AGE_W-1:0] LIMIT_M1 = AGE_W'(LIMIT - 1);

   typedef struct packed {
      logic [RD_WIDTH-1:0]   rd;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   entry_t             push_entry;
   entry_t             head_entry;
   logic [PTR_W-1:0]   head_ptr;
   logic [PTR_W-1:0]   tail_ptr;
   logic [CNT_W-1:0]   count;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic               capture;
   logic               retire;
   logic [ERR_BITS-1:0] ev;
   logic [ERR_BITS-1:0] base_sticky;
   first_err_e          base_first;
   first_err_e          first_err_q;
   logic [AGE_W-1:0]    age [DEPTH];

   assign capture    = mem_valid && mem_read && mem_reg_write && (mem_rd != '0);
   assign retire     = wb_valid && wb_mem_read && wb_reg_write && (wb_rd != '0);
   assign push_entry = '{rd: mem_rd, data: mem_data};

   ltrk_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .flush      (flush),
      .push_entry (push_entry),
      .head_entry (head_entry),
      .head_ptr   (head_ptr),
      .tail_ptr   (tail_ptr),
      .count      (count),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   // Age counts cycles since the entry became visible, so age == LIMIT-1 marks its last legal cycle.
   always_comb begin
      ev   = '0;
      push = 1'b0;
      pop  = 1'b0;
      if (!flush) begin
         if (retire) begin
            if (fifo_empty) begin
               ev[ERR_SPURIOUS] = 1'b1;
            end else begin
               pop = 1'b1;
               if (head_entry.rd != wb_rd)     ev[ERR_RD_MISMATCH]   = 1'b1;
               if (head_entry.data != wb_data) ev[ERR_DATA_MISMATCH] = 1'b1;
            end
         end else if (!fifo_empty && (age[head_ptr] >= LIMIT_M1)) begin
            pop              = 1'b1;
            ev[ERR_TIMEOUT]  = 1'b1;
         end
         if (capture) begin
            if (!fifo_full || pop) push = 1'b1;
            else                   ev[ERR_OVERFLOW] = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) age[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (flush || (push && (tail_ptr == PTR_W'(i)))) age[i] <= '0;
            else if (age[i] != AGE_SAT)                      age[i] <= age[i] + AGE_W'(1);
         end
      end
   end

   always_comb begin
      base_sticky = clear_errors ? '0 : err_sticky;
      base_first  = clear_errors ? FE_NONE : first_err_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         err_pulse   <= '0;
         err_sticky  <= '0;
         first_err_q <= FE_NONE;
      end else begin
         err_pulse   <= ev;
         err_sticky  <= base_sticky | ev;
         first_err_q <= (base_first == FE_NONE) ? first_err_code(ev) : base_first;
      end
   end

   assign first_err   = first_err_q;
   assign outstanding = count;
   assign full        = fifo_full;

endmodule

// File: tb/tb_load_writeback_tracker.sv
// Randomized and directed bench for load_writeback_tracker; a default and a strict-latency instance share stimulus.
`timescale 1ns/1ps
module tb_load_writeback_tracker;

   logic        clock = 1'b0;
   logic        rst_n;
   logic        mem_valid, mem_read, mem_reg_write;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        wb_valid, wb_mem_read, wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        flush, clear_errors;

   logic [2:0]  outstanding0, outstanding1;
   logic        full0, full1;
   logic [4:0]  sticky0, sticky1, pulse0, pulse1;
   logic [2:0]  first0, first1;

   always #5 clock = ~clock;

   load_writeback_tracker #(.DATA_WIDTH(32), .RD_WIDTH(5), .DEPTH(4), .MAX_LATENCY(8), .STRICT_NEXT_CYCLE(0)) dut0 (
      .clock(clock), .reset(rst_n),
      .mem_valid(mem_valid), .mem_read(mem_read), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_data(mem_data),
      .wb_valid(wb_valid), .wb_mem_read(wb_mem_read), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush), .clear_errors(clear_errors),
      .outstanding(outstanding0), .full(full0), .err_sticky(sticky0), .err_pulse(pulse0), .first_err(first0));

   load_writeback_tracker #(.DATA_WIDTH(32), .RD_WIDTH(5), .DEPTH(4), .MAX_LATENCY(8), .STRICT_NEXT_CYCLE(1)) dut1 (
      .clock(clock), .reset(rst_n),
      .mem_valid(mem_valid), .mem_read(mem_read), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_data(mem_data),
      .wb_valid(wb_valid), .wb_mem_read(wb_mem_read), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush), .clear_errors(clear_errors),
      .outstanding(outstanding1), .full(full1), .err_sticky(sticky1), .err_pulse(pulse1), .first_err(first1));

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a list of pending loads stamped with their capture cycle.
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      int          cap;
   } ment_t;

   ment_t      mq0[$];
   ment_t      mq1[$];
   logic [4:0] m_pulse  [2];
   logic [4:0] m_sticky [2];
   logic [2:0] m_first  [2];
   int         m_cyc;

   task automatic model_step(input int k);
      ment_t      q[$];
      ment_t      h;
      logic [4:0] ev;
      logic [2:0] f;
      bit         cap_ok, ret_ok;
      int         lim;
      lim = (k == 0) ? 8 : 1;
      if (k == 0) q = mq0; else q = mq1;
      ev     = '0;
      cap_ok = mem_valid && mem_read && mem_reg_write && (mem_rd != 0);
      ret_ok = wb_valid && wb_mem_read && wb_reg_write && (wb_rd != 0);
      if (flush) begin
         q.delete();
      end else begin
         if (ret_ok) begin
            if (q.size() == 0) ev[1] = 1'b1;
            else begin
               h = q.pop_front();
               if (h.rd != wb_rd)     ev[2] = 1'b1;
               if (h.data != wb_data) ev[3] = 1'b1;
            end
         end else if (q.size() > 0 && (m_cyc - q[0].cap) >= lim) begin
            q.delete(0);
            ev[4] = 1'b1;
         end
         if (cap_ok) begin
            if (q.size() < 4) begin
               h.rd = mem_rd; h.data = mem_data; h.cap = m_cyc;
               q.push_back(h);
            end else ev[0] = 1'b1;
         end
      end
      f = clear_errors ? 3'd0 : m_first[k];
      for (int b = 0; b < 5; b++) if (f == 3'd0 && ev[b]) f = 3'(b + 1);
      m_pulse[k]  = ev;
      m_sticky[k] = (clear_errors ? 5'd0 : m_sticky[k]) | ev;
      m_first[k]  = f;
      if (k == 0) mq0 = q; else mq1 = q;
   endtask

   always @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         mq0.delete(); mq1.delete();
         for (int k = 0; k < 2; k++) begin
            m_pulse[k] = '0; m_sticky[k] = '0; m_first[k] = '0;
         end
         m_cyc = 0;
      end else begin
         m_cyc++;
         model_step(0);
         model_step(1);
      end
   end

   always @(negedge clock) begin
      if (cmp_en && rst_n === 1'b1) begin
         check("outstanding0", outstanding0, mq0.size());
         check("full0", full0, mq0.size() == 4);
         check("pulse0", pulse0, m_pulse[0]);
         check("sticky0", sticky0, m_sticky[0]);
         check("first0", first0, m_first[0]);
         check("outstanding1", outstanding1, mq1.size());
         check("full1", full1, mq1.size() == 4);
         check("pulse1", pulse1, m_pulse[1]);
         check("sticky1", sticky1, m_sticky[1]);
         check("first1", first1, m_first[1]);
      end
   end

   task automatic step(input bit cap, input logic [4:0] rd, input logic [31:0] d,
                       input bit ret, input logic [4:0] wrd, input logic [31:0] wd,
                       input bit fl, input bit clr);
      mem_valid = cap; mem_read = cap; mem_reg_write = cap; mem_rd = rd; mem_data = d;
      wb_valid = ret; wb_mem_read = ret; wb_reg_write = ret; wb_rd = wrd; wb_data = wd;
      flush = fl; clear_errors = clr;
      @(negedge clock);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   logic [36:0] sq[$];

   initial begin
      rst_n = 1'b0;
      mem_valid = 0; mem_read = 0; mem_reg_write = 0; mem_rd = 0; mem_data = 0;
      wb_valid = 0; wb_mem_read = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0;
      flush = 0; clear_errors = 0;
      repeat (3) @(negedge clock);
      check("reset_outstanding0", outstanding0, 0);
      check("reset_full0", full0, 0);
      check("reset_sticky0", sticky0, 0);
      check("reset_pulse0", pulse0, 0);
      check("reset_first0", first0, 0);
      check("reset_outstanding1", outstanding1, 0);
      #1 rst_n = 1'b1;
      cmp_en = 1'b1;
      @(negedge clock);

      // Single load, retired on the next cycle.
      step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      check("basic_outstanding_after_load", outstanding0, 1);
      step(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0);
      check("basic_outstanding_after_wb", outstanding0, 0);
      check("basic_sticky0", sticky0, 0);
      check("basic_sticky1", sticky1, 0);

      // Fill to four, overflow with a fifth, then drain in order.
      for (int i = 1; i <= 4; i++) step(1, 5'(i), 32'h100 + i, 0, 0, 0, 0, 0);
      step(1, 5'd6, 32'h999, 0, 0, 0, 0, 0);
      check("ovf_pulse0", pulse0, 5'b00001);
      check("ovf_first0", first0, 1);
      check("ovf_outstanding0", outstanding0, 4);
      check("ovf_full0", full0, 1);
      for (int i = 1; i <= 4; i++) step(0, 0, 0, 1, 5'(i), 32'h100 + i, 0, 0);
      check("ovf_drain_outstanding0", outstanding0, 0);
      check("ovf_drain_sticky0", sticky0, 5'b00001);

      // rd and data mismatch in the same cycle.
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 5'd7, 32'hA5A50007, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 5'd8, 32'h12345678, 0, 0);
      check("mm_pulse0", pulse0, 5'b01100);
      check("mm_sticky0", sticky0, 5'b01100);
      check("mm_first0", first0, 3);
      check("mm_outstanding0", outstanding0, 0);

      // Strict instance: late writeback times out, then shows up as spurious.
      repeat (10) idle();
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 5'd9, 32'hC0FFEE09, 0, 0, 0, 0, 0);
      idle();
      check("strict_timeout_pulse1", pulse1, 5'b10000);
      check("strict_outstanding1", outstanding1, 0);
      step(0, 0, 0, 1, 5'd9, 32'hC0FFEE09, 0, 0);
      check("strict_spurious_pulse1", pulse1, 5'b00010);
      check("strict_first1", first1, 5);
      check("strict_sticky1", sticky1, 5'b10010);
      check("lat2_pulse0", pulse0, 0);

      // Spurious retire on empty queue, then flush with three outstanding.
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 5'd3, 32'h0, 0, 0);
      check("spur_pulse0", pulse0, 5'b00010);
      for (int i = 1; i <= 3; i++) step(1, 5'(i), 32'h200 + i, 0, 0, 0, 0, 0);
      check("preflush_outstanding0", outstanding0, 3);
      step(1, 5'd4, 32'h204, 1, 5'd1, 32'h201, 1, 0);
      check("flush_outstanding0", outstanding0, 0);
      check("flush_pulse0", pulse0, 0);
      check("flush_outstanding1", outstanding1, 0);

      // clear_errors coinciding with a fresh data mismatch keeps that bit.
      step(1, 5'd11, 32'h0B0B0B0B, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 5'd11, 32'h0B0B0B0A, 0, 1);
      check("clr_sticky0", sticky0, 5'b01000);
      check("clr_first0", first0, 4);
      check("clr_pulse0", pulse0, 5'b01000);

      // Asynchronous reset mid-cycle with loads outstanding and errors latched.
      step(1, 5'd12, 32'h12, 0, 0, 0, 0, 0);
      step(1, 5'd13, 32'h13, 0, 0, 0, 0, 0);
      check("prereset_outstanding0", outstanding0, 2);
      #3 rst_n = 1'b0;
      #1;
      check("arst_outstanding0", outstanding0, 0);
      check("arst_full0", full0, 0);
      check("arst_sticky0", sticky0, 0);
      check("arst_pulse0", pulse0, 0);
      check("arst_first0", first0, 0);
      check("arst_outstanding1", outstanding1, 0);
      idle();
      #1 rst_n = 1'b1;

      // Randomized traffic; writebacks mostly follow issued loads in order.
      for (int n = 0; n < 3000; n++) begin
         mem_valid     = ($urandom % 100) < 45;
         mem_read      = ($urandom % 8) != 0;
         mem_reg_write = ($urandom % 8) != 0;
         mem_rd        = (($urandom % 10) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         mem_data      = $urandom;
         if (($urandom % 100) < 40) begin
            wb_valid     = 1'b1;
            wb_mem_read  = ($urandom % 10) != 0;
            wb_reg_write = ($urandom % 10) != 0;
            if (sq.size() > 0 && ($urandom % 6) != 0) begin
               {wb_rd, wb_data} = sq.pop_front();
               if (($urandom % 12) == 0) wb_data = wb_data ^ 32'h1;
               if (($urandom % 12) == 0) wb_rd = 5'($urandom);
            end else begin
               wb_rd   = 5'($urandom);
               wb_data = $urandom;
            end
         end else begin
            wb_valid = 1'b0; wb_mem_read = 1'b0; wb_reg_write = 1'b0;
            wb_rd = 5'($urandom); wb_data = $urandom;
         end
         flush        = ($urandom % 80) == 0;
         clear_errors = ($urandom % 25) == 0;
         if (flush) sq.delete();
         else if (mem_valid && mem_read && mem_reg_write && mem_rd != 0) sq.push_back({mem_rd, mem_data});
         if (sq.size() > 8) sq.delete(0);
         @(negedge clock);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
